// File: rtl/minirisc_pkg.sv
// Shared KGP-miniRISC definitions: instruction field positions, fetch-state encoding
// and default fetch parameters.
package minirisc_pkg;

    localparam int FETCH_ADDR_W  = 32;
    localparam int FETCH_INSTR_W = 32;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 26;
    localparam int FUNC_MSB = 5;
    localparam int FUNC_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        ISSUE = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and instruction memory (slave).
interface instr_fetch_unit_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    logic               req;
    logic [ADDR_W-1:0]  addr;
    logic               ready;
    logic               rvalid;
    logic [INSTR_W-1:0] rdata;

    modport master (output req, output addr, input ready, input rvalid, input rdata);
    modport slave  (input req, input addr, output ready, output rvalid, output rdata);
endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter with word-aligned load and +4 increment; load has priority.
module fetch_pc_reg #(
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] load_pc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Redirect targets are forced to a word boundary; increment wraps modulo 2^ADDR_W.
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_pc & ~ADDR_W'(3);
        end else if (inc) begin
            pc_d = pc_q + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch unit: one-outstanding-request instruction fetch with downstream stall and
// branch/jump redirect, presenting opcode/func, PC and PC+4 to decode.
module instr_fetch_unit
    import minirisc_pkg::*;
#(
    parameter int ADDR_W  = FETCH_ADDR_W,
    parameter int INSTR_W = FETCH_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_fetch_unit_if.master   imem,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [ADDR_W-1:0]    redirect_pc,
    output logic                 instr_valid,
    output logic [INSTR_W-1:0]   instr,
    output logic [5:0]           opcode,
    output logic [5:0]           func,
    output logic [ADDR_W-1:0]    pc_out,
    output logic [ADDR_W-1:0]    link_pc
);

    fetch_state_e        state_q, state_d;
    logic                drop_q, drop_d;
    logic                instr_valid_q, instr_valid_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [ADDR_W-1:0]   pc_out_q, pc_out_d;
    logic [ADDR_W-1:0]   link_pc_q, link_pc_d;
    logic [ADDR_W-1:0]   pc;
    logic                accept;
    logic                capture;

    assign accept  = (state_q == REQ) && imem.ready;
    assign capture = (state_q == WAIT) && imem.rvalid && !drop_q && !redirect_valid;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk     (clk),
        .rst     (rst),
        .load    (redirect_valid),
        .inc     (capture),
        .load_pc (redirect_pc),
        .pc      (pc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            drop_q        <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            pc_out_q      <= RESET_PC;
            link_pc_q     <= RESET_PC + ADDR_W'(4);
        end else begin
            state_q       <= state_d;
            drop_q        <= drop_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            pc_out_q      <= pc_out_d;
            link_pc_q     <= link_pc_d;
        end
    end

    // drop marks an in-flight fetch whose data must be discarded after a redirect.
    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (accept) begin
                    state_d = WAIT;
                    drop_d  = redirect_valid;
                end
            end
            WAIT: begin
                if (imem.rvalid) begin
                    drop_d  = 1'b0;
                    state_d = (drop_q || redirect_valid) ? REQ : ISSUE;
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            ISSUE: begin
                if (!stall || redirect_valid) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        instr_valid_d = (state_d == ISSUE);
        instr_d       = instr_q;
        pc_out_d      = pc_out_q;
        link_pc_d     = link_pc_q;
        if (capture) begin
            instr_d   = imem.rdata;
            pc_out_d  = pc;
            link_pc_d = pc + ADDR_W'(4);
        end
        imem.req  = (state_q == REQ);
        imem.addr = pc;
    end

    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[OPC_MSB:OPC_LSB];
    assign func        = instr_q[FUNC_MSB:FUNC_LSB];
    assign pc_out      = pc_out_q;
    assign link_pc     = link_pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by randomized traffic, checked
// against a transaction-level model of the expected instruction stream.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [31:0] pc_out;
    logic [31:0] link_pc;

    instr_fetch_unit_if #(.ADDR_W(32), .INSTR_W(32)) imem_bus ();

    instr_fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (imem_bus),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .opcode         (opcode),
        .func           (func),
        .pc_out         (pc_out),
        .link_pc        (link_pc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Expected-stream model: the next address that must be fetched and issued.
    logic [31:0] fetch_pc;
    int          issued = 0;
    int          last_issue_cyc = 0;
    int          issue_gap = 0;
    logic        prev_valid, prev_stall, prev_redir;
    logic [31:0] prev_instr, prev_pc;
    logic        fired;

    // Memory responder state and knobs.
    logic        pend = 1'b0;
    logic [31:0] pend_addr;
    int          pend_cnt;
    int          lat_min = 1, lat_max = 1;
    int          ready_pct = 100;
    int          ready_block = 0;
    int          spur_pct = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0001;
        if (a == 32'h4) return 32'h0400_0002;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs against the model, act as memory, drive stall/redirect.
    // rmode: 0 none, 1 redirect now, 2 redirect only with a request (ready forced), 3 only with rvalid.
    task automatic applyStimulus(input logic st, input int rmode, input logic [31:0] rpc);
        logic [31:0] exp_w;
        logic        rv_now;
        logic        rdy;
        logic        do_redir;
        if (!prev_valid && instr_valid === 1'b1) begin
            exp_w = mem_word(fetch_pc);
            checkOutput("issue_pc", pc_out, fetch_pc);
            checkOutput("issue_instr", instr, exp_w);
            checkOutput("issue_opcode", 32'(opcode), 32'(exp_w[31:26]));
            checkOutput("issue_func", 32'(func), 32'(exp_w[5:0]));
            checkOutput("issue_link", link_pc, fetch_pc + 32'd4);
            issue_gap      = cyc - last_issue_cyc;
            last_issue_cyc = cyc;
            fetch_pc       = fetch_pc + 32'd4;
            issued++;
        end else if (prev_valid) begin
            if (prev_stall && !prev_redir) begin
                checkOutput("hold_valid", 32'(instr_valid), 32'd1);
                checkOutput("hold_instr", instr, prev_instr);
                checkOutput("hold_pc", pc_out, prev_pc);
            end else begin
                checkOutput("window_end", 32'(instr_valid), 32'd0);
            end
        end
        if (imem_bus.req === 1'b1) begin
            checkOutput("req_addr", imem_bus.addr, fetch_pc);
            checkOutput("req_while_valid", 32'(instr_valid), 32'd0);
        end

        rv_now = 1'b0;
        imem_bus.rvalid = 1'b0;
        imem_bus.rdata  = $urandom;
        if (pend) begin
            if (pend_cnt == 0) begin
                imem_bus.rvalid = 1'b1;
                imem_bus.rdata  = mem_word(pend_addr);
                pend   = 1'b0;
                rv_now = 1'b1;
            end else begin
                pend_cnt--;
            end
        end else if (int'($urandom_range(99)) < spur_pct) begin
            imem_bus.rvalid = 1'b1;
        end
        if (rmode == 2) begin
            rdy = 1'b1;
        end else if (ready_block > 0) begin
            rdy = 1'b0;
            if (imem_bus.req === 1'b1) ready_block--;
        end else begin
            rdy = (int'($urandom_range(99)) < ready_pct);
        end
        imem_bus.ready = rdy;
        if (imem_bus.req === 1'b1 && rdy) begin
            pend      = 1'b1;
            pend_addr = imem_bus.addr;
            pend_cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
        end

        do_redir = (rmode == 1) || (rmode == 2 && imem_bus.req === 1'b1) || (rmode == 3 && rv_now);
        redirect_valid = do_redir;
        redirect_pc    = rpc;
        stall          = st;
        if (do_redir) begin
            fetch_pc = rpc & ~32'd3;
            fired    = 1'b1;
        end
        prev_valid = instr_valid;
        prev_stall = st;
        prev_redir = do_redir;
        prev_instr = instr;
        prev_pc    = pc_out;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic runUntilIssue(input logic st, input int budget);
        int start;
        start = issued;
        for (int i = 0; i < budget && issued == start; i++) applyStimulus(st, 0, 32'h0);
        checkOutput("issue_timeout", 32'(issued), 32'(start + 1));
    endtask

    // Asynchronous reset with bus noise, then release with a possible late rvalid.
    task automatic doReset(input int n);
        logic late;
        rst = 1'b0;
        redirect_valid = 1'b0;
        stall = 1'b0;
        #1;
        checkOutput("rst_req", 32'(imem_bus.req), 32'd0);
        checkOutput("rst_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_pc_out", pc_out, 32'h0);
        checkOutput("rst_link", link_pc, 32'h4);
        checkOutput("rst_instr", instr, 32'h0);
        for (int i = 0; i < n; i++) begin
            imem_bus.ready  = $urandom_range(1);
            imem_bus.rvalid = $urandom_range(1);
            imem_bus.rdata  = $urandom;
            @(posedge clk);
            #1;
            cyc++;
            checkOutput("rst_hold_req", 32'(imem_bus.req), 32'd0);
            checkOutput("rst_hold_valid", 32'(instr_valid), 32'd0);
        end
        late = pend;
        pend = 1'b0;
        rst = 1'b1;
        imem_bus.ready  = 1'b0;
        imem_bus.rvalid = late;
        imem_bus.rdata  = 32'hDEAD_BEEF;
        checkOutput("rel_req0", 32'(imem_bus.req), 32'd0);
        @(posedge clk);
        #1;
        cyc++;
        imem_bus.rvalid = 1'b0;
        checkOutput("rel_req1", 32'(imem_bus.req), 32'd1);
        checkOutput("rel_addr", imem_bus.addr, 32'h0);
        fetch_pc       = 32'h0;
        prev_valid     = 1'b0;
        prev_stall     = 1'b0;
        prev_redir     = 1'b0;
        last_issue_cyc = cyc;
    endtask

    initial begin
        int issued0;
        rst = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        imem_bus.ready = 1'b0;
        imem_bus.rvalid = 1'b0;
        imem_bus.rdata = 32'h0;
        fetch_pc = 32'h0;
        prev_valid = 1'b0;
        prev_stall = 1'b0;
        prev_redir = 1'b0;
        prev_instr = 32'h0;
        prev_pc = 32'h0;
        fired = 1'b0;
        #2;
        doReset(3);

        $display("[TB] straight-line fetch");
        runUntilIssue(1'b0, 20);
        checkOutput("t2_pc0", pc_out, 32'h0);
        runUntilIssue(1'b0, 20);
        checkOutput("t2_pc1", pc_out, 32'h4);
        checkOutput("t2_link1", link_pc, 32'h8);
        checkOutput("t2_gap", 32'(issue_gap), 32'd3);

        $display("[TB] stall hold");
        runUntilIssue(1'b1, 20);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 0, 32'h0);
        runUntilIssue(1'b0, 20);
        checkOutput("t3_next_pc", pc_out, 32'hC);

        $display("[TB] redirect while fetch in flight");
        lat_min = 3;
        lat_max = 3;
        applyStimulus(1'b0, 1, 32'h10);
        for (int i = 0; i < 20 && !(pend && pend_addr == 32'h10); i++) applyStimulus(1'b0, 0, 32'h0);
        checkOutput("t4_accept", pend_addr, 32'h10);
        applyStimulus(1'b0, 1, 32'h43);
        runUntilIssue(1'b0, 20);
        checkOutput("t4_pc", pc_out, 32'h40);
        checkOutput("t4_instr", instr, mem_word(32'h40));

        $display("[TB] redirect with accept and with rvalid");
        lat_min = 1;
        lat_max = 1;
        fired = 1'b0;
        for (int i = 0; i < 20 && !fired; i++) applyStimulus(1'b0, 2, 32'h80);
        runUntilIssue(1'b0, 20);
        checkOutput("t5_accept_pc", pc_out, 32'h80);
        fired = 1'b0;
        for (int i = 0; i < 20 && !fired; i++) applyStimulus(1'b0, 3, 32'hC6);
        runUntilIssue(1'b0, 20);
        checkOutput("t5_rvalid_pc", pc_out, 32'hC4);

        $display("[TB] wrap with slow memory");
        applyStimulus(1'b0, 1, 32'hFFFF_FFFC);
        ready_block = 3;
        runUntilIssue(1'b0, 30);
        checkOutput("t6_pc", pc_out, 32'hFFFF_FFFC);
        checkOutput("t6_link", link_pc, 32'h0);
        runUntilIssue(1'b0, 20);
        checkOutput("t6_next", pc_out, 32'h0);

        $display("[TB] randomized traffic");
        ready_pct = 70;
        lat_min = 1;
        lat_max = 3;
        spur_pct = 10;
        issued0 = issued;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) doReset(2);
            applyStimulus(int'($urandom_range(99)) < 30,
                          (int'($urandom_range(99)) < 5) ? 1 : 0, $urandom);
        end
        checkOutput("rand_progress", 32'(issued > issued0 + 20), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
